// File: rtl/key_sequencer_if.sv
// Bus between the key sequencer and the key repository that holds the expanded
// round keys. The sequencer is the master; the repository is the slave.
interface key_sequencer_if;
  logic [0:255] cipherkey;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic         start_exp;
  logic         busy_exp;
  logic [3:0]   round_count;
  logic [0:127] roundkey;

  modport master (
    output cipherkey, keylength128, keylength192, keylength256, start_exp, round_count,
    input  busy_exp, roundkey
  );

  modport slave (
    input  cipherkey, keylength128, keylength192, keylength256, start_exp, round_count,
    output busy_exp, roundkey
  );
endinterface

// File: rtl/key_sequencer.sv
// Hands a cipher key to the key repository, waits for expansion, then sweeps the
// round keys out in encrypt (0..Nr) or decrypt (Nr..0) order as a registered stream.
module key_sequencer (
  input  logic                  mclk,
  input  logic                  arst_n,
  input  logic [0:255]          key_in,
  input  logic [1:0]            keylen,
  input  logic                  key_load,
  input  logic                  run,
  input  logic                  decrypt,
  key_sequencer_if.master       repo,
  output logic                  key_ready,
  output logic                  key_err,
  output logic [0:127]          rk_out,
  output logic                  rk_valid,
  output logic [3:0]            rk_round,
  output logic                  rk_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    READY   = 3'd4,
    RUN     = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [0:255] cipherkey_q, cipherkey_d;
  logic [2:0]   keylen_oh_q, keylen_oh_d;
  logic [3:0]   nr_q, nr_d;
  logic         dec_q, dec_d;
  logic [3:0]   round_count_q, round_count_d;
  logic         key_ready_q, key_ready_d;
  logic         key_err_q, key_err_d;
  logic [0:127] rk_out_q, rk_out_d;
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic         rk_last_q, rk_last_d;

  logic         accepting;
  logic         load_ok;
  logic         run_ok;
  logic         stepping;
  logic         at_term;
  logic [3:0]   terminal;

  assign accepting = (state_q == IDLE) || (state_q == READY);
  assign load_ok   = accepting && key_load && (keylen != 2'b11);
  assign run_ok    = (state_q == READY) && run && !key_load;
  assign terminal  = dec_q ? 4'd0 : nr_q;
  assign at_term   = (round_count_q == terminal);
  // The cycle after rk_last is a drain cycle in RUN, so key_ready lands one cycle later.
  assign stepping  = (state_q == RUN) && !rk_last_q;

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, READY: begin
        if (key_load) begin
          if (keylen != 2'b11) state_d = START;
        end else if (run_ok) begin
          state_d = RUN;
        end
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (repo.busy_exp)  state_d = WAIT_LO;
      WAIT_LO: if (!repo.busy_exp) state_d = READY;
      RUN:     if (rk_last_q)      state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cipherkey_d   = cipherkey_q;
    keylen_oh_d   = keylen_oh_q;
    nr_d          = nr_q;
    dec_d         = dec_q;
    round_count_d = round_count_q;
    if (load_ok) begin
      cipherkey_d = key_in;
      unique case (keylen)
        2'b00:   begin keylen_oh_d = 3'b100; nr_d = 4'd10; end
        2'b01:   begin keylen_oh_d = 3'b010; nr_d = 4'd12; end
        default: begin keylen_oh_d = 3'b001; nr_d = 4'd14; end
      endcase
    end
    if (run_ok) begin
      dec_d         = decrypt;
      round_count_d = decrypt ? nr_q : 4'd0;
    end else if (stepping && !at_term) begin
      round_count_d = dec_q ? (round_count_q - 4'd1) : (round_count_q + 4'd1);
    end
    key_ready_d = (state_d == READY);
    key_err_d   = accepting && key_load && (keylen == 2'b11);
    rk_valid_d  = stepping;
    rk_last_d   = stepping && at_term;
    rk_out_d    = stepping ? repo.roundkey : rk_out_q;
    rk_round_d  = stepping ? round_count_q : rk_round_q;
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      cipherkey_q   <= '0;
      keylen_oh_q   <= '0;
      nr_q          <= '0;
      dec_q         <= 1'b0;
      round_count_q <= '0;
      key_ready_q   <= 1'b0;
      key_err_q     <= 1'b0;
      rk_out_q      <= '0;
      rk_valid_q    <= 1'b0;
      rk_round_q    <= '0;
      rk_last_q     <= 1'b0;
    end else begin
      cipherkey_q   <= cipherkey_d;
      keylen_oh_q   <= keylen_oh_d;
      nr_q          <= nr_d;
      dec_q         <= dec_d;
      round_count_q <= round_count_d;
      key_ready_q   <= key_ready_d;
      key_err_q     <= key_err_d;
      rk_out_q      <= rk_out_d;
      rk_valid_q    <= rk_valid_d;
      rk_round_q    <= rk_round_d;
      rk_last_q     <= rk_last_d;
    end
  end

  always_comb begin
    repo.start_exp    = (state_q == START);
    repo.cipherkey    = cipherkey_q;
    repo.keylength128 = keylen_oh_q[2];
    repo.keylength192 = keylen_oh_q[1];
    repo.keylength256 = keylen_oh_q[0];
    repo.round_count  = round_count_q;
    key_ready         = key_ready_q;
    key_err           = key_err_q;
    rk_out            = rk_out_q;
    rk_valid          = rk_valid_q;
    rk_round          = rk_round_q;
    rk_last           = rk_last_q;
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Scoreboard bench for key_sequencer with a behavioural key repository that
// pulses busy_exp after start_exp and serves round keys from a table.
module tb_key_sequencer;
  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic         arst_n;
  logic [0:255] key_in;
  logic [1:0]   keylen;
  logic         key_load, run, decrypt;
  logic         key_ready, key_err, rk_valid, rk_last;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;

  key_sequencer_if bus();

  key_sequencer dut (
    .mclk(mclk), .arst_n(arst_n), .key_in(key_in), .keylen(keylen),
    .key_load(key_load), .run(run), .decrypt(decrypt), .repo(bus),
    .key_ready(key_ready), .key_err(key_err), .rk_out(rk_out),
    .rk_valid(rk_valid), .rk_round(rk_round), .rk_last(rk_last)
  );

  // Repository model: busy_exp high for 5 cycles starting 2 cycles after start_exp.
  logic [0:127] rk_tab [16];
  logic [3:0]   rcnt = 4'd0;
  assign bus.roundkey = rk_tab[bus.round_count];
  assign bus.busy_exp = (rcnt >= 4'd3) && (rcnt <= 4'd7);
  always @(posedge mclk) begin
    if (bus.start_exp) rcnt <= 4'd1;
    else if (rcnt != 4'd0 && rcnt != 4'd8) rcnt <= rcnt + 4'd1;
    else rcnt <= 4'd0;
  end

  typedef enum logic [1:0] {E_START, E_ERR, E_RK} ekind_t;
  typedef struct {
    ekind_t       kind;
    logic [0:255] key;
    logic [2:0]   oh;
    logic [0:127] rk;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic void chk(string name, logic [255:0] got, logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  function automatic bit pop_kind(ekind_t k, output exp_t e);
    if (q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_%s: got an output, expected none", k.name());
      return 1'b0;
    end
    e = q.pop_front();
    chk("event_kind", 256'(e.kind), 256'(k));
    return e.kind == k;
  endfunction

  // Monitor: compares every DUT output event against the head of the queue.
  logic prev_last = 1'b0;
  always @(negedge mclk) begin
    exp_t e;
    if (prev_last) chk("key_ready_after_last", 256'(key_ready), 256'(1));
    prev_last = rk_valid && rk_last;
    if (bus.start_exp === 1'b1) begin
      if (pop_kind(E_START, e)) begin
        chk("cipherkey", 256'(bus.cipherkey), 256'(e.key));
        chk("keylength", 256'({bus.keylength128, bus.keylength192, bus.keylength256}), 256'(e.oh));
      end
    end
    if (key_err === 1'b1) void'(pop_kind(E_ERR, e));
    if (rk_valid === 1'b1) begin
      if (pop_kind(E_RK, e)) begin
        chk("rk_out", 256'(rk_out), 256'(e.rk));
        chk("rk_round", 256'(rk_round), 256'(e.rnd));
        chk("rk_last", 256'(rk_last), 256'(e.last));
      end
    end
  end

  task automatic push_start(logic [0:255] k, logic [2:0] oh);
    exp_t e;
    e = '{E_START, k, oh, 128'h0, 4'h0, 1'b0};
    q.push_back(e);
  endtask

  task automatic push_rk(int r, bit last);
    exp_t e;
    e = '{E_RK, 256'h0, 3'b000, rk_tab[r], 4'(r), last};
    q.push_back(e);
  endtask

  task automatic push_sweep(int nr, bit dec);
    for (int i = 0; i <= nr; i++) push_rk(dec ? nr - i : i, i == nr);
  endtask

  // Intermediate round keys are placeholders; round 0 and round Nr carry the reference values.
  task automatic set_tab(int nr, logic [0:127] r0, logic [0:127] rn);
    for (int r = 0; r < 16; r++) rk_tab[r] = {4{28'hC0FFEE0, 4'(r)}};
    rk_tab[0]  = r0;
    rk_tab[nr] = rn;
  endtask

  task automatic load(logic [0:255] k, logic [1:0] kl, logic r);
    @(negedge mclk);
    key_in = k; keylen = kl; key_load = 1'b1; run = r;
    @(negedge mclk);
    key_load = 1'b0; run = 1'b0;
  endtask

  task automatic pulse_run(logic dec);
    @(negedge mclk);
    run = 1'b1; decrypt = dec;
    @(negedge mclk);
    run = 1'b0;
  endtask

  task automatic wait_ready(string name);
    for (int i = 0; i < 200 && key_ready !== 1'b1; i++) @(negedge mclk);
    chk(name, 256'(key_ready), 256'(1));
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_cipherkey"}, 256'(bus.cipherkey), 256'(0));
    chk({tag, "_keylength"}, 256'({bus.keylength128, bus.keylength192, bus.keylength256}), 256'(0));
    chk({tag, "_start_exp"}, 256'(bus.start_exp), 256'(0));
    chk({tag, "_round_count"}, 256'(bus.round_count), 256'(0));
    chk({tag, "_key_ready"}, 256'(key_ready), 256'(0));
    chk({tag, "_key_err"}, 256'(key_err), 256'(0));
    chk({tag, "_rk_out"}, 256'(rk_out), 256'(0));
    chk({tag, "_rk_valid"}, 256'(rk_valid), 256'(0));
    chk({tag, "_rk_round"}, 256'(rk_round), 256'(0));
    chk({tag, "_rk_last"}, 256'(rk_last), 256'(0));
  endtask

  logic [0:255] k128, k192, k256;

  initial begin
    arst_n = 1'b0; key_in = '0; keylen = 2'b00; key_load = 1'b0; run = 1'b0; decrypt = 1'b0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    repeat (2) @(negedge mclk);
    check_all_zero("reset");
    arst_n = 1'b1;

    // 128-bit load; run during WAIT_LO must be ignored
    push_start(k128, 3'b100);
    load(k128, 2'b00, 1'b0);
    for (int i = 0; i < 50 && bus.busy_exp !== 1'b1; i++) @(negedge mclk);
    chk("busy_seen", 256'(bus.busy_exp), 256'(1));
    pulse_run(1'b0);
    wait_ready("ready_128");

    // encrypt sweep; key_load during RUN must be ignored
    set_tab(10, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    push_sweep(10, 1'b0);
    pulse_run(1'b0);
    repeat (2) @(negedge mclk);
    load(k256, 2'b10, 1'b0);
    wait_ready("ready_after_enc128");
    chk("round_count_hold", 256'(bus.round_count), 256'(10));
    chk("cipherkey_stable", 256'(bus.cipherkey), 256'(k128));

    // illegal key length: single key_err, no expansion, key_ready kept
    q.push_back('{E_ERR, 256'h0, 3'b000, 128'h0, 4'h0, 1'b0});
    load(k256, 2'b11, 1'b0);
    repeat (3) @(negedge mclk);
    chk("key_ready_after_err", 256'(key_ready), 256'(1));
    chk("key_err_cleared", 256'(key_err), 256'(0));

    // 192-bit decrypt sweep
    push_start(k192, 3'b010);
    load(k192, 2'b01, 1'b0);
    wait_ready("ready_192");
    set_tab(12, 128'h8e73b0f7da0e6452c810f32b809079e5, 128'he98ba06f448c773c8ecc720401002202);
    push_sweep(12, 1'b1);
    pulse_run(1'b1);
    wait_ready("ready_after_dec192");

    // key_load and run together: expansion only
    push_start(k256, 3'b001);
    load(k256, 2'b10, 1'b1);
    wait_ready("ready_256");
    set_tab(14, 128'h603deb1015ca71be2b73aef0857d7781, 128'hfe4890d1e6188d0b046df344706c631e);
    push_sweep(14, 1'b1);
    pulse_run(1'b1);
    wait_ready("ready_after_dec256");
    chk("round_count_hold_dec", 256'(bus.round_count), 256'(0));

    // reset in the middle of an encrypt sweep
    for (int r = 0; r < 5; r++) push_rk(r, 1'b0);
    pulse_run(1'b0);
    for (int i = 0; i < 50 && !(rk_valid === 1'b1 && rk_round == 4'd4); i++) @(negedge mclk);
    chk("reached_round4", 256'(rk_round), 256'(4));
    #1 arst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge mclk);
    arst_n = 1'b1;
    pulse_run(1'b0);
    repeat (20) @(negedge mclk);
    chk("no_ready_after_reset", 256'(key_ready), 256'(0));
    chk("no_valid_after_reset", 256'(rk_valid), 256'(0));

    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
